// File: rtl/activation_writeback.sv
// Leaky-ReLU activation and writeback for two systolic columns: per-column activation
// register, per-column FIFO that absorbs the one-cycle column skew, and a ready/valid row port.
module activation_writeback #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ROWS       = 2,
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] lr_leak_factor_in,
    input  logic              lr_valid_in_1,
    input  logic              lr_valid_in_2,
    input  logic [DATA_W-1:0] lr_data_in_1,
    input  logic [DATA_W-1:0] lr_data_in_2,
    output logic              lr_ready_out,
    output logic              ub_wr_valid_out,
    input  logic              ub_wr_ready_in,
    output logic [DATA_W-1:0] ub_wr_data_out_1,
    output logic [DATA_W-1:0] ub_wr_data_out_2,
    output logic [ROW_W-1:0]  ub_wr_row_out,
    output logic              tile_done_out,
    output logic              overflow_err_out
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PW    = 2 * DATA_W;
    localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
    localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(ROWS - 1);

    // Negative inputs are scaled by the leak with a floor shift, then clamped to the data range.
    function automatic logic [DATA_W-1:0] leaky_relu(input logic signed [DATA_W-1:0] z,
                                                     input logic signed [DATA_W-1:0] leak);
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] scaled;
        prod   = PW'(z) * PW'(leak);
        scaled = prod >>> FRAC_W;
        if (!z[DATA_W-1]) begin
            leaky_relu = z;
        end else if (scaled > SAT_MAX) begin
            leaky_relu = SAT_MAX[DATA_W-1:0];
        end else if (scaled < SAT_MIN) begin
            leaky_relu = SAT_MIN[DATA_W-1:0];
        end else begin
            leaky_relu = scaled[DATA_W-1:0];
        end
    endfunction

    logic [DATA_W-1:0] din_s [2];
    logic [1:0]        vin_s;
    logic [DATA_W-1:0] act_q [2];
    logic [1:0]        act_v_q;
    logic [DATA_W-1:0] mem_q [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q  [2];
    logic [PTR_W-1:0]  rd_q  [2];
    logic [CNT_W-1:0]  cnt_q [2];
    logic [CNT_W-1:0]  cnt_d [2];
    logic [1:0]        push_s;
    logic [1:0]        drop_s;
    logic              pop_s;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              tile_done_q;
    logic              ovf_q;

    assign din_s[0] = lr_data_in_1;
    assign din_s[1] = lr_data_in_2;
    assign vin_s    = {lr_valid_in_2, lr_valid_in_1};

    // FIFO bookkeeping: a push into a full FIFO survives only when the same edge pops.
    always_comb begin
        pop_s   = valid_q && ub_wr_ready_in;
        push_s  = 2'b00;
        drop_s  = 2'b00;
        cnt_d   = cnt_q;
        for (int k = 0; k < 2; k++) begin
            if (cnt_q[k] == CNT_W'(FIFO_DEPTH)) begin
                push_s[k] = act_v_q[k] && pop_s;
                drop_s[k] = act_v_q[k] && !pop_s;
            end else begin
                push_s[k] = act_v_q[k];
                drop_s[k] = 1'b0;
            end
            if (push_s[k] && !pop_s) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else if (!push_s[k] && pop_s) begin
                cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
        valid_d = (cnt_d[0] != '0) && (cnt_d[1] != '0);
        ready_d = (cnt_d[0] <= CNT_W'(FIFO_DEPTH - 2)) && (cnt_d[1] <= CNT_W'(FIFO_DEPTH - 2));
        if (pop_s) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
            row_d = row_q;
        end
    end

    // Activation registers, FIFO storage and row/status state; FIFO storage is never reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                act_q[k] <= '0;
                wr_q[k]  <= '0;
                rd_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
            act_v_q     <= 2'b00;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            row_q       <= '0;
            tile_done_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                act_v_q[k] <= vin_s[k];
                if (vin_s[k]) begin
                    act_q[k] <= leaky_relu(din_s[k], lr_leak_factor_in);
                end
                if (push_s[k]) begin
                    mem_q[k][wr_q[k]] <= act_q[k];
                    wr_q[k]           <= wr_q[k] + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_q[k] <= rd_q[k] + PTR_W'(1);
                end
                cnt_q[k] <= cnt_d[k];
            end
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            row_q       <= row_d;
            tile_done_q <= pop_s && (row_q == ROW_LAST);
            if (|drop_s) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign lr_ready_out     = ready_q;
    assign ub_wr_valid_out  = valid_q;
    assign ub_wr_data_out_1 = valid_q ? mem_q[0][rd_q[0]] : '0;
    assign ub_wr_data_out_2 = valid_q ? mem_q[1][rd_q[1]] : '0;
    assign ub_wr_row_out    = row_q;
    assign tile_done_out    = tile_done_q;
    assign overflow_err_out = ovf_q;

endmodule
